// File: rtl/lc3_ctrl_pkg.sv
// Shared types and encodings for the SLC-3 control sequencer.
package lc3_ctrl_pkg;

    // Operand selects that depend on IR bits get their own states,
    // so every output is a function of state and counter alone.
    typedef enum logic [4:0] {
        S_HALTED,
        S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE,
        S_ADD_R, S_ADD_I, S_AND_R, S_AND_I, S_NOT,
        S_BR_TAKEN, S_JMP,
        S_JSR1, S_JSR2_OFF, S_JSR2_REG,
        S_LDR1, S_LDR2, S_LDR3,
        S_STR1, S_STR2, S_STR3,
        S_PAUSE1, S_PAUSE_WAIT, S_PAUSE2
    } state_t;

    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_JSR   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_LDR   = 4'b0110;
    localparam logic [3:0] OP_STR   = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_PAUSE = 4'b1101;

    localparam logic [1:0] PCMUX_INC   = 2'd0;
    localparam logic [1:0] PCMUX_BUS   = 2'd1;
    localparam logic [1:0] PCMUX_ADDER = 2'd2;

    localparam logic [1:0] ADDR2_ZERO  = 2'd0;
    localparam logic [1:0] ADDR2_OFF6  = 2'd1;
    localparam logic [1:0] ADDR2_OFF9  = 2'd2;
    localparam logic [1:0] ADDR2_OFF11 = 2'd3;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_AND   = 2'd1;
    localparam logic [1:0] ALU_NOT   = 2'd2;
    localparam logic [1:0] ALU_PASSA = 2'd3;

endpackage

// File: rtl/mem_wait_counter.sv
// Wait-state counter for SRAM accesses; done marks the last strobe cycle.
module mem_wait_counter #(
    parameter int MEM_WAIT = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic done
);

    logic [3:0] cnt;

    assign done = en && (cnt == 4'(MEM_WAIT - 1));

    // Count while a memory state is active; idle keeps it at zero so every
    // memory state starts from a cleared count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= 4'd0;
        else if (!en || done)
            cnt <= 4'd0;
        else
            cnt <= cnt + 4'd1;
    end

endmodule

// File: rtl/lc3_control_sequencer.sv
// Moore control FSM driving the SLC-3 datapath and SRAM strobes.
module lc3_control_sequencer
    import lc3_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 3
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    output logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
    output logic       GatePC, GateMDR, GateALU, GateMARMUX,
    output logic [1:0] PCMUX,
    output logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       Mem_OE, Mem_WE,
    output logic       Halted
);

    state_t state, next;
    logic   mem_en, mem_done;

    assign mem_en = (state == S_FETCH2) || (state == S_LDR2) || (state == S_STR3);

    mem_wait_counter #(.MEM_WAIT(MEM_WAIT)) u_wait (
        .clk   (Clk),
        .rst_n (Reset_n),
        .en    (mem_en),
        .done  (mem_done)
    );

    // State register; reset drops straight to Halted even mid-access.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= S_HALTED;
        else          state <= next;
    end

    // Next-state and Moore output decode.
    always_comb begin
        next = state;
        {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED} = 8'd0;
        {GatePC, GateMDR, GateALU, GateMARMUX} = 4'd0;
        {DRMUX, SR1MUX, SR2MUX, ADDR1MUX} = 4'd0;
        PCMUX = PCMUX_INC; ADDR2MUX = ADDR2_ZERO; ALUK = ALU_ADD;
        {Mem_OE, Mem_WE, Halted} = 3'd0;
        case (state)
            S_HALTED: begin
                Halted = 1'b1;
                if (Run) next = S_FETCH1;
            end
            S_FETCH1: begin
                GatePC = 1'b1; LD_MAR = 1'b1; LD_PC = 1'b1;
                next = S_FETCH2;
            end
            S_FETCH2: begin
                Mem_OE = 1'b1; LD_MDR = mem_done;
                if (mem_done) next = S_FETCH3;
            end
            S_FETCH3: begin
                GateMDR = 1'b1; LD_IR = 1'b1;
                next = S_DECODE;
            end
            S_DECODE: begin
                LD_BEN = 1'b1;
                case (Opcode)
                    OP_ADD:   next = IR_5 ? S_ADD_I : S_ADD_R;
                    OP_AND:   next = IR_5 ? S_AND_I : S_AND_R;
                    OP_NOT:   next = S_NOT;
                    OP_BR:    next = BEN ? S_BR_TAKEN : S_FETCH1;
                    OP_JMP:   next = S_JMP;
                    OP_JSR:   next = S_JSR1;
                    OP_LDR:   next = S_LDR1;
                    OP_STR:   next = S_STR1;
                    OP_PAUSE: next = S_PAUSE1;
                    default:  next = S_FETCH1;
                endcase
            end
            S_ADD_R, S_ADD_I, S_AND_R, S_AND_I: begin
                SR1MUX = 1'b1;
                SR2MUX = (state == S_ADD_I) || (state == S_AND_I);
                ALUK = ((state == S_AND_R) || (state == S_AND_I)) ? ALU_AND : ALU_ADD;
                GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
                next = S_FETCH1;
            end
            S_NOT: begin
                ALUK = ALU_NOT; SR1MUX = 1'b1;
                GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
                next = S_FETCH1;
            end
            S_BR_TAKEN, S_JSR2_OFF: begin
                ADDR1MUX = 1'b0;
                ADDR2MUX = (state == S_BR_TAKEN) ? ADDR2_OFF9 : ADDR2_OFF11;
                PCMUX = PCMUX_ADDER; LD_PC = 1'b1;
                next = S_FETCH1;
            end
            S_JMP, S_JSR2_REG: begin
                SR1MUX = 1'b1; ALUK = ALU_PASSA; GateALU = 1'b1;
                PCMUX = PCMUX_BUS; LD_PC = 1'b1;
                next = S_FETCH1;
            end
            S_JSR1: begin
                GatePC = 1'b1; DRMUX = 1'b1; LD_REG = 1'b1;
                next = IR_11 ? S_JSR2_OFF : S_JSR2_REG;
            end
            S_LDR1, S_STR1: begin
                ADDR1MUX = 1'b1; SR1MUX = 1'b1; ADDR2MUX = ADDR2_OFF6;
                GateMARMUX = 1'b1; LD_MAR = 1'b1;
                next = (state == S_LDR1) ? S_LDR2 : S_STR2;
            end
            S_LDR2: begin
                Mem_OE = 1'b1; LD_MDR = mem_done;
                if (mem_done) next = S_LDR3;
            end
            S_LDR3: begin
                GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
                next = S_FETCH1;
            end
            S_STR2: begin
                ALUK = ALU_PASSA; GateALU = 1'b1; LD_MDR = 1'b1;
                next = S_STR3;
            end
            S_STR3: begin
                Mem_WE = 1'b1;
                if (mem_done) next = S_FETCH1;
            end
            S_PAUSE1: begin
                LD_LED = 1'b1;
                next = S_PAUSE_WAIT;
            end
            // Two-phase wait: press, then release, so one press is one step.
            S_PAUSE_WAIT: if (Continue) next = S_PAUSE2;
            S_PAUSE2:     if (!Continue) next = S_FETCH1;
            default:      next = S_HALTED;
        endcase
    end

endmodule

// File: tb/tb_lc3_control_sequencer.sv
// Directed bench for lc3_control_sequencer with hand-derived control words.
module tb_lc3_control_sequencer;

    localparam int MW = 3;

    // Control word bit positions, MSB first.
    localparam logic [24:0] L_MAR  = 25'd1 << 24;
    localparam logic [24:0] L_MDR  = 25'd1 << 23;
    localparam logic [24:0] L_IR   = 25'd1 << 22;
    localparam logic [24:0] L_BEN  = 25'd1 << 21;
    localparam logic [24:0] L_CC   = 25'd1 << 20;
    localparam logic [24:0] L_REG  = 25'd1 << 19;
    localparam logic [24:0] L_PC   = 25'd1 << 18;
    localparam logic [24:0] L_LED  = 25'd1 << 17;
    localparam logic [24:0] G_PC   = 25'd1 << 16;
    localparam logic [24:0] G_MDR  = 25'd1 << 15;
    localparam logic [24:0] G_ALU  = 25'd1 << 14;
    localparam logic [24:0] G_MMX  = 25'd1 << 13;
    localparam logic [24:0] PCM1   = 25'd1 << 11;
    localparam logic [24:0] PCM2   = 25'd2 << 11;
    localparam logic [24:0] DRM    = 25'd1 << 10;
    localparam logic [24:0] SR1M   = 25'd1 << 9;
    localparam logic [24:0] SR2M   = 25'd1 << 8;
    localparam logic [24:0] A1M    = 25'd1 << 7;
    localparam logic [24:0] A2_1   = 25'd1 << 5;
    localparam logic [24:0] A2_2   = 25'd2 << 5;
    localparam logic [24:0] A2_3   = 25'd3 << 5;
    localparam logic [24:0] ALUK3  = 25'd3 << 3;
    localparam logic [24:0] OE     = 25'd1 << 2;
    localparam logic [24:0] WE     = 25'd1 << 1;
    localparam logic [24:0] HALT   = 25'd1;

    localparam logic [24:0] E_F1   = G_PC | L_MAR | L_PC;
    localparam logic [24:0] E_F3   = G_MDR | L_IR;

    logic       Clk = 1'b0, Reset_n = 1'b0, Run = 1'b0, Continue = 1'b0;
    logic [3:0] Opcode = 4'd0;
    logic       IR_5 = 1'b0, IR_11 = 1'b0, BEN = 1'b0;
    logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic       GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0] PCMUX, ADDR2MUX, ALUK;
    logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX, Mem_OE, Mem_WE, Halted;
    logic [24:0] ctl;
    int n_chk = 0, n_bad = 0;

    lc3_control_sequencer #(.MEM_WAIT(MW)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Run(Run), .Continue(Continue),
        .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
        .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
        .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
        .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX),
        .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
        .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .Halted(Halted)
    );

    assign ctl = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
                  GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, DRMUX, SR1MUX,
                  SR2MUX, ADDR1MUX, ADDR2MUX, ALUK, Mem_OE, Mem_WE, Halted};

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [24:0] got, input logic [24:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Walks Fetch1..Decode; leaves the DUT in the first execute state.
    task automatic fetch(input logic [3:0] op);
        chk("fetch1", ctl, E_F1);
        Opcode = op;
        tick();
        for (int i = 0; i < MW; i++) begin
            chk("fetch2", ctl, (i == MW - 1) ? (OE | L_MDR) : OE);
            tick();
        end
        chk("fetch3", ctl, E_F3);
        tick();
        chk("decode", ctl, L_BEN);
        tick();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        tick(); tick();
        chk("reset", ctl, HALT);
        Reset_n = 1'b1;
        tick(); tick();
        chk("halt_no_run", ctl, HALT);
        Run = 1'b1; tick(); Run = 1'b0;

        // ADD immediate
        IR_5 = 1'b1;
        fetch(4'b0001);
        chk("add_imm", ctl, SR1M | SR2M | G_ALU | L_REG | L_CC);
        tick();

        // BR not taken, then taken
        BEN = 1'b0;
        fetch(4'b0000);
        chk("br_nt", ctl, E_F1);
        BEN = 1'b1;
        fetch(4'b0000);
        chk("br_taken", ctl, A2_2 | PCM2 | L_PC);
        tick();

        // JMP and JSR (offset form)
        fetch(4'b1100);
        chk("jmp", ctl, SR1M | ALUK3 | G_ALU | PCM1 | L_PC);
        tick();
        IR_11 = 1'b1;
        fetch(4'b0100);
        chk("jsr1", ctl, G_PC | DRM | L_REG);
        tick();
        chk("jsr2", ctl, A2_3 | PCM2 | L_PC);
        tick();

        // PAUSE: hold, press, release
        fetch(4'b1101);
        chk("pause_led", ctl, L_LED);
        tick();
        for (int i = 0; i < 50; i++) begin
            chk("pause_hold", ctl, 25'd0);
            tick();
        end
        Continue = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("pause2_hold", ctl, 25'd0);
        end
        Continue = 1'b0;
        tick();

        // STR full sequence
        fetch(4'b0111);
        chk("str1", ctl, A1M | SR1M | A2_1 | G_MMX | L_MAR);
        tick();
        chk("str2", ctl, ALUK3 | G_ALU | L_MDR);
        tick();
        for (int i = 0; i < MW; i++) begin
            chk("str3_we", ctl, WE);
            tick();
        end
        chk("str_done", ctl, E_F1);

        // STR interrupted by reset on the 2nd write cycle
        fetch(4'b0111);
        tick(); tick();
        chk("str3_we1", ctl, WE);
        tick();
        chk("str3_we2", ctl, WE);
        Reset_n = 1'b0;
        #1;
        chk("rst_async", ctl, HALT);
        tick();
        Reset_n = 1'b1;
        tick(); tick(); tick();
        chk("rst_stay_halt", ctl, HALT);
        Run = 1'b1; tick(); Run = 1'b0;
        chk("restart", ctl, E_F1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
